// File: rtl/semafor_pkg.sv
// semafor_pkg: state encoding, phase-counter width and lamp one-hot codes
// shared by the per-direction traffic-light sequencer.
package semafor_pkg;
    localparam int PCNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VERDE  = 3'd1,
        S_GALBEN = 3'd2,
        S_LIBER  = 3'd3,
        S_DONE   = 3'd4
    } stare_t;

    // Lamp order is {verde, galben, rosu}.
    localparam logic [2:0] LAMP_VERDE  = 3'b100;
    localparam logic [2:0] LAMP_GALBEN = 3'b010;
    localparam logic [2:0] LAMP_ROSU   = 3'b001;

    function automatic logic [2:0] lampi(input stare_t s);
        return s == S_VERDE ? LAMP_VERDE : s == S_GALBEN ? LAMP_GALBEN : LAMP_ROSU;
    endfunction
endpackage

// File: rtl/divizor_tick.sv
// divizor_tick: prescaler counting 0..FACTOR-1 with synchronous restart;
// tick is high for the single cycle the count sits at its terminal value.
module divizor_tick #(
    parameter int FACTOR = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = FACTOR > 1 ? $clog2(FACTOR) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(FACTOR - 1);

    always_ff @(posedge clk) begin
        if (rst || restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/semafor_directie.sv
// semafor_directie: per-approach green/yellow/all-red sequencer with done/clear
// handshake. Optional SEMAFOR_CONTOR_EN adds the ticuri_ramase countdown output.
module semafor_directie
    import semafor_pkg::*;
#(
    parameter int FACTOR_DIVIZARE = 10,
    parameter int T_VERDE         = 5,
    parameter int T_GALBEN        = 2,
    parameter int T_LIBER         = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic done,
    output logic verde,
    output logic galben,
    output logic rosu
`ifdef SEMAFOR_CONTOR_EN
    ,
    output logic [PCNT_W-1:0] ticuri_ramase
`endif
);
    stare_t stare, urm;
    logic [PCNT_W-1:0] faza, faza_urm;
    logic tick, restart, sfarsit;

    function automatic logic [PCNT_W-1:0] durata(input stare_t s);
        return s == S_VERDE  ? PCNT_W'(T_VERDE)  :
               s == S_GALBEN ? PCNT_W'(T_GALBEN) :
               s == S_LIBER  ? PCNT_W'(T_LIBER)  : '0;
    endfunction

    divizor_tick #(.FACTOR(FACTOR_DIVIZARE)) u_div (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        sfarsit = tick && faza == durata(stare) - 1'b1;
        urm = S_IDLE;
        case (stare)
            S_IDLE:   urm = enable ? S_VERDE : S_IDLE;
            S_VERDE:  urm = (!enable || sfarsit) ? S_GALBEN : S_VERDE;
            S_GALBEN: urm = sfarsit ? S_LIBER : S_GALBEN;
            S_LIBER:  urm = sfarsit ? S_DONE : S_LIBER;
            S_DONE:   urm = S_DONE;
            default:  urm = S_IDLE;
        endcase
        // clear overrides every transition, including a pending restart from idle
        if (clear)
            urm = S_IDLE;
        // both counters restart on every state entry and idle outside timed phases
        restart  = urm != stare || stare == S_IDLE || stare == S_DONE;
        faza_urm = restart ? '0 : faza + {{(PCNT_W-1){1'b0}}, tick};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stare                 <= S_IDLE;
            faza                  <= '0;
            {verde, galben, rosu} <= LAMP_ROSU;
            done                  <= 1'b0;
        end else begin
            stare                 <= urm;
            faza                  <= faza_urm;
            {verde, galben, rosu} <= lampi(urm);
            done                  <= urm == S_DONE;
        end
    end

`ifdef SEMAFOR_CONTOR_EN
    always_ff @(posedge clk) begin
        if (rst)
            ticuri_ramase <= '0;
        else
            ticuri_ramase <= durata(urm) - faza_urm;
    end
`endif
endmodule
